// File: rtl/fwd_hazard_unit_pkg.sv
// Shared select encoding, state encoding and select-priority helper for the forwarding unit.
package fwd_hazard_unit_pkg;

  localparam int unsigned SEL_W = 2;

  typedef logic [SEL_W-1:0] fwd_sel_t;

  // Forward-select encoding; 2'b10 is never produced.
  localparam fwd_sel_t FWD_ALU  = 2'b00;
  localparam fwd_sel_t FWD_MEM  = 2'b01;
  localparam fwd_sel_t FWD_NONE = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  // Newer writer (EX) wins over older writer (MEM); otherwise read the register file.
  function automatic fwd_sel_t pick_sel(input logic ex_hit, input logic mem_hit);
    fwd_sel_t sel;
    if (ex_hit) begin
      sel = FWD_ALU;
    end else if (mem_hit) begin
      sel = FWD_MEM;
    end else begin
      sel = FWD_NONE;
    end
    return sel;
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID/EX-boundary hazard bus: decode sources, EX/MEM writers, flush in; selects and stall controls out.
interface fwd_hazard_unit_if #(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned N_SRC  = 2
) ();

  logic                    id_valid;
  logic [N_SRC*REG_AW-1:0] id_src;
  logic [N_SRC-1:0]        id_src_used;
  logic [REG_AW-1:0]       ex_wr_add;
  logic                    ex_wb;
  logic                    ex_is_load;
  logic [REG_AW-1:0]       mem_wr_add;
  logic                    mem_wb;
  logic                    flush;
  logic [2*N_SRC-1:0]      fwd_sel;
  logic                    stall;
  logic                    bubble;

  // Pipeline side: drives decode and writer information, consumes selects and stall controls.
  modport master (
    output id_valid, id_src, id_src_used,
    output ex_wr_add, ex_wb, ex_is_load,
    output mem_wr_add, mem_wb, flush,
    input  fwd_sel, stall, bubble
  );

  // Hazard unit side.
  modport slave (
    input  id_valid, id_src, id_src_used,
    input  ex_wr_add, ex_wb, ex_is_load,
    input  mem_wr_add, mem_wb, flush,
    output fwd_sel, stall, bubble
  );

endinterface

// File: rtl/fwd_cmp_slot.sv
// One source-operand slot: address match against the EX and MEM writers plus select priority.
module fwd_cmp_slot
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW      = 3,
  parameter int unsigned ZERO_REG_EN = 0
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] src,
  input  logic              src_used,
  input  logic [REG_AW-1:0] ex_wr_add,
  input  logic              ex_wb,
  input  logic [REG_AW-1:0] mem_wr_add,
  input  logic              mem_wb,
  output logic              ex_hit_c,
  output fwd_sel_t          sel_c
);

  logic src_live_c;
  logic mem_hit_c;

  // A slot can only match when the operand is really read and is not the hard-wired zero register.
  always_comb begin
    src_live_c = id_valid && src_used && !((ZERO_REG_EN != 0) && (src == '0));
    ex_hit_c   = src_live_c && ex_wb  && (src == ex_wr_add);
    mem_hit_c  = src_live_c && mem_wb && (src == mem_wr_add);
    sel_c      = pick_sel(ex_hit_c, mem_hit_c);
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding-select register and load-use stall controller at the ID/EX boundary.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int unsigned REG_AW      = 3,
  parameter int unsigned N_SRC       = 2,
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned ZERO_REG_EN = 0
) (
  input  logic              clk,
  input  logic              rst,
  fwd_hazard_unit_if.slave  bus
);

  localparam int unsigned CNT_W    = $clog2(LOAD_LAT + 1);
  localparam int unsigned FSEL_W   = SEL_W * N_SRC;
  localparam logic [FSEL_W-1:0] SEL_ALL_NONE = {N_SRC{FWD_NONE}};

  state_e              state_q;
  state_e              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_d;
  logic [FSEL_W-1:0]   fwd_sel_q;
  logic [FSEL_W-1:0]   fwd_sel_d;
  logic [N_SRC-1:0]    ex_hit_c;
  logic [FSEL_W-1:0]   sel_c;
  logic                hazard_c;
  logic                stall_c;
  logic                bubble_c;

  // Per-slot comparators.
  for (genvar k = 0; k < N_SRC; k++) begin : g_slot
    fwd_cmp_slot #(
      .REG_AW      (REG_AW),
      .ZERO_REG_EN (ZERO_REG_EN)
    ) u_slot (
      .id_valid   (bus.id_valid),
      .src        (bus.id_src[k*REG_AW +: REG_AW]),
      .src_used   (bus.id_src_used[k]),
      .ex_wr_add  (bus.ex_wr_add),
      .ex_wb      (bus.ex_wb),
      .mem_wr_add (bus.mem_wr_add),
      .mem_wb     (bus.mem_wb),
      .ex_hit_c   (ex_hit_c[k]),
      .sel_c      (sel_c[SEL_W*k +: SEL_W])
    );
  end

  // Load-use hazard: an operand needs the result of a load that is still in EX.
  always_comb begin
    hazard_c = bus.ex_is_load && (|ex_hit_c);
  end

  // State, counter and select registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      fwd_sel_q <= SEL_ALL_NONE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      fwd_sel_q <= fwd_sel_d;
    end
  end

  // Next state: a 1-cycle load latency needs no HOLD, the first stall cycle is spent in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (hazard_c && (LOAD_LAT > 1)) begin
            state_d = ST_HOLD;
            cnt_d   = CNT_W'(LOAD_LAT - 1);
          end
        end
        ST_HOLD: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs: stall/bubble react in the hazard cycle itself; selects are captured for EX.
  always_comb begin
    stall_c   = 1'b0;
    bubble_c  = 1'b0;
    fwd_sel_d = SEL_ALL_NONE;
    if (!bus.flush) begin
      case (state_q)
        ST_IDLE: begin
          if (hazard_c) begin
            stall_c  = 1'b1;
            bubble_c = 1'b1;
          end else begin
            fwd_sel_d = sel_c;
          end
        end
        ST_HOLD: begin
          stall_c  = 1'b1;
          bubble_c = 1'b1;
        end
        default: begin
          stall_c  = 1'b0;
          bubble_c = 1'b0;
        end
      endcase
    end
  end

  assign bus.fwd_sel = fwd_sel_q;
  assign bus.stall   = stall_c;
  assign bus.bubble  = bubble_c;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench: two unit configurations share one stimulus stream, each checked against a reference model.
module tb_fwd_hazard_unit;

  localparam int unsigned REG_AW = 3;
  localparam int unsigned N_SRC  = 2;
  localparam int unsigned LAT_A  = 3;
  localparam int unsigned ZERO_A = 0;
  localparam int unsigned LAT_B  = 1;
  localparam int unsigned ZERO_B = 1;

  typedef struct packed {
    logic       chk_comb;
    logic       stall;
    logic       bubble;
    logic [3:0] fwd;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic id_valid;
  logic [5:0] id_src;
  logic [1:0] id_used;
  logic [2:0] ex_wr;
  logic ex_wb;
  logic ex_ld;
  logic [2:0] mem_wr;
  logic mem_wb;
  logic flush;

  int checks = 0;
  int errors = 0;
  bit primed = 0;

  exp_t q_a[$];
  exp_t q_b[$];
  int hold_left[2];
  logic [3:0] fwd_q[2];

  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.REG_AW(REG_AW), .N_SRC(N_SRC)) bus_a ();
  fwd_hazard_unit_if #(.REG_AW(REG_AW), .N_SRC(N_SRC)) bus_b ();

  assign bus_a.id_valid = id_valid;   assign bus_b.id_valid = id_valid;
  assign bus_a.id_src = id_src;       assign bus_b.id_src = id_src;
  assign bus_a.id_src_used = id_used; assign bus_b.id_src_used = id_used;
  assign bus_a.ex_wr_add = ex_wr;     assign bus_b.ex_wr_add = ex_wr;
  assign bus_a.ex_wb = ex_wb;         assign bus_b.ex_wb = ex_wb;
  assign bus_a.ex_is_load = ex_ld;    assign bus_b.ex_is_load = ex_ld;
  assign bus_a.mem_wr_add = mem_wr;   assign bus_b.mem_wr_add = mem_wr;
  assign bus_a.mem_wb = mem_wb;       assign bus_b.mem_wb = mem_wb;
  assign bus_a.flush = flush;         assign bus_b.flush = flush;

  fwd_hazard_unit #(.REG_AW(REG_AW), .N_SRC(N_SRC), .LOAD_LAT(LAT_A), .ZERO_REG_EN(ZERO_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  fwd_hazard_unit #(.REG_AW(REG_AW), .N_SRC(N_SRC), .LOAD_LAT(LAT_B), .ZERO_REG_EN(ZERO_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  // Reference: per-slot selects from the matching rules; a stall is a count of remaining cycles.
  task automatic model(input int i);
    exp_t e;
    logic [3:0] nxt;
    logic [2:0] s;
    bit live, exm, memm, hz, zero;
    int lat;
    lat  = (i == 0) ? int'(LAT_A) : int'(LAT_B);
    zero = (i == 0) ? (ZERO_A != 0) : (ZERO_B != 0);
    nxt  = 4'b1111;
    hz   = 0;
    for (int k = 0; k < 2; k++) begin
      s    = id_src[k*3 +: 3];
      live = id_valid && id_used[k] && !(zero && s == 3'd0);
      exm  = live && ex_wb && (s == ex_wr);
      memm = live && mem_wb && (s == mem_wr);
      nxt[2*k +: 2] = exm ? 2'b00 : (memm ? 2'b01 : 2'b11);
      if (exm && ex_ld) hz = 1;
    end
    e.chk_comb = !rst;
    e.fwd      = fwd_q[i];
    e.stall    = 1'b0;
    e.bubble   = 1'b0;
    if (rst) begin
      hold_left[i] = 0;
      fwd_q[i]     = 4'b1111;
    end else if (flush) begin
      hold_left[i] = 0;
      fwd_q[i]     = 4'b1111;
    end else if (hold_left[i] > 0) begin
      e.stall = 1'b1; e.bubble = 1'b1;
      hold_left[i] = hold_left[i] - 1;
      fwd_q[i]     = 4'b1111;
    end else if (hz) begin
      e.stall = 1'b1; e.bubble = 1'b1;
      hold_left[i] = lat - 1;
      fwd_q[i]     = 4'b1111;
    end else begin
      fwd_q[i] = nxt;
    end
    if (primed) begin
      if (i == 0) q_a.push_back(e);
      else        q_b.push_back(e);
    end
  endtask

  // One cycle of stimulus; expected responses are queued for the monitor.
  task automatic drive(input logic r, input logic v, input logic [2:0] s1, input logic [2:0] s0,
                       input logic [1:0] u, input logic [2:0] ew, input logic ewb, input logic eld,
                       input logic [2:0] mw, input logic mwb, input logic fl);
    @(posedge clk);
    #1;
    rst = r; id_valid = v; id_src = {s1, s0}; id_used = u;
    ex_wr = ew; ex_wb = ewb; ex_ld = eld; mem_wr = mw; mem_wb = mwb; flush = fl;
    model(0);
    model(1);
    primed = 1;
  endtask

  task automatic check(input string tag, input exp_t e, input logic st, input logic bb, input logic [3:0] f);
    checks++;
    if (f !== e.fwd) begin
      errors++;
      $display("FAIL %s fwd_sel got %b want %b at %0t", tag, f, e.fwd, $time);
    end
    if (e.chk_comb) begin
      checks++;
      if (st !== e.stall || bb !== e.bubble) begin
        errors++;
        $display("FAIL %s stall/bubble got %b/%b want %b/%b at %0t", tag, st, bb, e.stall, e.bubble, $time);
      end
    end
  endtask

  // Monitor: compare each DUT's outputs mid-cycle against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (q_a.size() > 0) begin
      e = q_a.pop_front();
      check("cfg_a", e, bus_a.stall, bus_a.bubble, bus_a.fwd_sel);
    end
    if (q_b.size() > 0) begin
      e = q_b.pop_front();
      check("cfg_b", e, bus_b.stall, bus_b.bubble, bus_b.fwd_sel);
    end
  end

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_src = '0; id_used = '0;
    ex_wr = '0; ex_wb = 1'b0; ex_ld = 1'b0; mem_wr = '0; mem_wb = 1'b0; flush = 1'b0;
    hold_left[0] = 0; hold_left[1] = 0;
    fwd_q[0] = 4'b1111; fwd_q[1] = 4'b1111;

    // reset, then idle
    repeat (2) drive(1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    // r3 from MEM in slot1, r5 from EX in slot0
    drive(0, 1, 3, 5, 2'b11, 5, 1, 0, 3, 1, 0);
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    // same address in EX and MEM: EX wins
    drive(0, 1, 6, 6, 2'b11, 6, 1, 0, 6, 1, 0);
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    // load-use on r2, then the load moves to MEM
    repeat (3) drive(0, 1, 0, 2, 2'b01, 2, 1, 1, 0, 0, 0);
    drive(0, 1, 0, 2, 2'b01, 0, 0, 0, 2, 1, 0);
    drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    // flush in the second stall cycle
    drive(0, 1, 0, 2, 2'b01, 2, 1, 1, 0, 0, 0);
    drive(0, 1, 0, 2, 2'b01, 2, 1, 1, 0, 0, 1);
    repeat (3) drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    // hard-wired zero register: cfg_b ignores r0, cfg_a stalls
    repeat (3) drive(0, 1, 0, 0, 2'b01, 0, 1, 1, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    // unused slot1 matches the load: no stall; then slot1 used: stall
    drive(0, 1, 4, 1, 2'b01, 4, 1, 1, 0, 0, 0);
    repeat (3) drive(0, 1, 4, 1, 2'b11, 4, 1, 1, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
    // reset in the middle of a stall
    drive(0, 1, 0, 3, 2'b01, 3, 1, 1, 0, 0, 0);
    drive(1, 1, 0, 3, 2'b01, 3, 1, 1, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);

    // randomized traffic with a dense address space for frequent matches
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 99) < 2) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 3)), 3'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)),
            3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
            3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 99) < 5) ? 1'b1 : 1'b0);
    end

    repeat (2) @(negedge clk);
    #1;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL drain pending got %0d/%0d want 0/0", q_a.size(), q_b.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_unit.md
Name: fwd_hazard_unit

Overview:
- Parametrised forwarding and load-use hazard unit; next generation of the combinational forwarding selector.
- Sits at the ID/EX boundary. Compares N_SRC decode-stage register addresses against the writers in EX and MEM.
- Registers the forward selects into EX, so they align with the consumer when it executes.
- Detects load-use hazards and holds the front end for LOAD_LAT cycles while injecting bubbles into EX.

Parameters:
- REG_AW, 3, register address width.
- N_SRC, 2, number of source operands compared per instruction (1..4).
- LOAD_LAT, 1, load-use stall cycles (1..7).
- ZERO_REG_EN, 0, if 1 register address 0 never matches (hard-wired zero).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- id_valid  in  1  a valid instruction is in ID.
- id_src  in  N_SRC*REG_AW  source addresses; slot k = bits [k*REG_AW +: REG_AW].
- id_src_used  in  N_SRC  per-slot "operand actually read".
- ex_wr_add  in  REG_AW  EX-stage destination.
- ex_wb  in  1  EX-stage writes back.
- ex_is_load  in  1  EX-stage instruction is a load.
- mem_wr_add  in  REG_AW  MEM-stage destination.
- mem_wb  in  1  MEM-stage writes back.
- flush  in  1  pipeline flush (branch or interrupt).
- fwd_sel  out  2*N_SRC  registered forward select per slot (slot k = bits [2k+1:2k]).
- stall  out  1  freeze PC and IF/ID.
- bubble  out  1  insert NOP into ID/EX this cycle.

Behaviour:
- Select encoding (shared constants):
  - 2'b00: forward from ALU pipe (EX/MEM result).
  - 2'b01: forward from MEM pipe (MEM/WB result).
  - 2'b11: no forward, use register file.
  - 2'b10: never produced.
- Slot k matches EX when all hold: id_valid, id_src_used[k], id_src[k]==ex_wr_add, ex_wb, and not (ZERO_REG_EN and id_src[k]==0). The MEM match is defined the same way against mem_wr_add/mem_wb.
- Priority: an EX match beats a MEM match (the newer writer wins). Next select = 00 on EX match, else 01 on MEM match, else 11.
- hazard = any slot matches EX while ex_is_load=1.
- State machine, states IDLE and HOLD, plus a down-counter cnt of width clog2(LOAD_LAT+1).
  - IDLE, hazard=0: stall=0, bubble=0; fwd_sel <= computed selects.
  - IDLE, hazard=1: stall=1 and bubble=1 in the same cycle (combinational). fwd_sel <= all 11.
    - If LOAD_LAT==1, stay in IDLE.
    - Otherwise go to HOLD with cnt <= LOAD_LAT-1.
  - HOLD: stall=1, bubble=1, fwd_sel <= all 11. cnt decrements; when cnt==1, go to IDLE next cycle. No hazard detection in HOLD.
  - Total stall cycles = LOAD_LAT exactly. On return to IDLE, selects are re-evaluated; the load is now in MEM or later, so a 01 select or a register-file read results.
- Latency: fwd_sel is valid one cycle after the instruction was in ID, i.e. while it is in EX.
- flush (highest priority after rst): next state IDLE, cnt <= 0, fwd_sel <= all 11. stall and bubble are forced 0 in the flush cycle.
- id_valid=0 produces no matches and no hazard; fwd_sel <= all 11.
- Reset: state IDLE, cnt 0, fwd_sel all 11, stall 0, bubble 0. Reset mid-HOLD aborts the stall on the next edge.
- Simultaneous hazard and flush: flush wins, no stall.
- Same address in EX and MEM with both wb=1: select 00. If EX is a load, stall instead.

Decomposition:
- Shared package: select constants FWD_ALU=2'b00, FWD_MEM=2'b01, FWD_NONE=2'b11; state encoding for IDLE/HOLD.
- One natural sub-module, fwd_cmp_slot: per-slot combinational match and priority logic, generated N_SRC times.
- The top level holds the state machine, counter and fwd_sel register.

Test Plan:
- rst=1 for 2 cycles, then id_valid=0 -> fwd_sel=all 11, stall=0, bubble=0.
- N_SRC=2, id_src={3,5}, ex_wr_add=5, ex_wb=1, ex_is_load=0, mem_wr_add=3, mem_wb=1 -> next cycle fwd_sel={01,00}, i.e. slot1=01 for r3 and slot0=00 for r5; no stall.
- LOAD_LAT=3, id_src slot0=2, ex_wr_add=2, ex_is_load=1, ex_wb=1 -> stall and bubble high for exactly 3 cycles. Then the same instruction with mem_wr_add=2, mem_wb=1 gives slot0=01.
- Same as the previous case, with flush asserted in the 2nd stall cycle -> stall=0 in that cycle and after; fwd_sel all 11; state IDLE.
- ZERO_REG_EN=1, id_src=0, ex_wr_add=0, ex_wb=1, ex_is_load=1 -> no stall, fwd_sel slot0=11. Repeat with ZERO_REG_EN=0 -> 1-cycle stall.
- id_src_used=2'b01, slot1 matches the EX load -> no stall. Set id_src_used=2'b11 -> stall for LOAD_LAT cycles.
